// File: rtl/udp_tx_pattern_gen.sv
// UDP payload source: fills the TX FIFO with one packet of payload words, then pulses tx_enable.
// Define UDP_TX_PATTERN_GEN_PRBS_EN to build the PRBS-31 data mode; otherwise mode 2 aliases mode 1.
module udp_tx_pattern_gen #(
  parameter int  DATA_W    = 64,
  parameter int  PAT_DEPTH = 4,
  parameter int  LEN_W     = 16,
  localparam int AW        = $clog2(PAT_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic              continuous,
  input  logic [LEN_W-1:0]  payload_bytes,
  input  logic [LEN_W-1:0]  gap_cycles,
  input  logic              pat_we,
  input  logic [AW-1:0]     pat_addr,
  input  logic [DATA_W-1:0] pat_wdata,
  input  logic              fifo_afull,
  output logic              wr_en,
  output logic [DATA_W-1:0] din,
  output logic              tx_enable,
  output logic [LEN_W-1:0]  tx_data_length,
  output logic [LEN_W-1:0]  tx_total_length,
  output logic              busy,
  output logic [LEN_W-1:0]  pkt_count
);

  localparam int               BYTES   = DATA_W / 8;
  localparam logic [LEN_W-1:0] BYTES_L = LEN_W'(BYTES);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_ARM, S_GAP} state_e;

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic                cont_q, cont_d;
  logic [LEN_W:0]      nwords_q, nwords_d, wcnt_q, wcnt_d;
  logic [LEN_W-1:0]    rem_q, rem_d, gap_q, gap_d, gcnt_q, gcnt_d, cnt_q, cnt_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic                stop_pend_q, stop_pend_d;
  logic                wr_en_q, wr_en_d, tx_en_q, tx_en_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [LEN_W-1:0]    dlen_q, dlen_d, tlen_q, tlen_d, pkt_q, pkt_d;
  logic [DATA_W-1:0]   pat_ram [PAT_DEPTH];
  logic [DATA_W-1:0]   word_raw, word;
  logic                last_word, gap_done;

`ifdef UDP_TX_PATTERN_GEN_PRBS_EN
  localparam logic [30:0] PRBS_SEED = 31'h7FFF_FFFF;
  logic [30:0]       prbs_q, prbs_d, prbs_next;
  logic [DATA_W-1:0] prbs_word;

  // Fibonacci x^31 + x^28 + 1, one output bit per step, first bit lands in word bit 0.
  always_comb begin
    prbs_next = prbs_q;
    prbs_word = '0;
    for (int i = 0; i < DATA_W; i++) begin
      prbs_word[i] = prbs_next[30] ^ prbs_next[27];
      prbs_next    = {prbs_next[29:0], prbs_word[i]};
    end
  end
`endif

  always_comb begin
    word_raw = pat_ram[idx_q];
    case (mode_q)
      2'd1:    word_raw = DATA_W'(cnt_q);
`ifdef UDP_TX_PATTERN_GEN_PRBS_EN
      2'd2:    word_raw = prbs_word;
`else
      2'd2:    word_raw = DATA_W'(cnt_q);
`endif
      default: ;
    endcase
  end

  // Only the high-order rem_q bytes of a short final word carry payload.
  assign last_word = (wcnt_q + 1'b1) == nwords_q;
  always_comb begin
    word = word_raw;
    for (int b = 0; b < BYTES; b++)
      if (last_word && rem_q != '0 && (LEN_W'(b) + rem_q) < BYTES_L) word[b*8 +: 8] = 8'h00;
  end

  assign gap_done = (gap_q == '0) || (gcnt_q == gap_q - 1'b1);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    state_d     = state_q;
    mode_d      = mode_q;
    cont_d      = cont_q;
    nwords_d    = nwords_q;
    rem_d       = rem_q;
    gap_d       = gap_q;
    gcnt_d      = gcnt_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    stop_pend_d = stop_pend_q;
    wr_en_d     = 1'b0;
    din_d       = din_q;
    tx_en_d     = 1'b0;
    dlen_d      = dlen_q;
    tlen_d      = tlen_q;
    pkt_d       = pkt_q;
`ifdef UDP_TX_PATTERN_GEN_PRBS_EN
    prbs_d      = prbs_q;
`endif
    if (state_q != S_IDLE && stop) stop_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start && payload_bytes != '0) begin
          state_d  = S_FILL;
          mode_d   = mode;
          cont_d   = continuous;
          gap_d    = gap_cycles;
          nwords_d = (LEN_W+1)'((payload_bytes + (BYTES - 1)) / BYTES);
          rem_d    = LEN_W'(payload_bytes % BYTES);
          dlen_d   = payload_bytes + LEN_W'(8);
          tlen_d   = payload_bytes + LEN_W'(28);
          wcnt_d   = '0;
          idx_d    = '0;
          cnt_d    = '0;
`ifdef UDP_TX_PATTERN_GEN_PRBS_EN
          prbs_d   = PRBS_SEED;
`endif
        end
      end
      S_FILL: begin
        if (!fifo_afull) begin
          wr_en_d = 1'b1;
          din_d   = word;
          wcnt_d  = wcnt_q + 1'b1;
          case (mode_q)
            2'd1:    cnt_d = cnt_q + 1'b1;
`ifdef UDP_TX_PATTERN_GEN_PRBS_EN
            2'd2:    prbs_d = prbs_next;
`else
            2'd2:    cnt_d = cnt_q + 1'b1;
`endif
            default: idx_d = (idx_q == AW'(PAT_DEPTH - 1)) ? '0 : idx_q + 1'b1;
          endcase
          if (last_word) state_d = S_ARM;
        end
      end
      S_ARM: begin
        tx_en_d = 1'b1;
        pkt_d   = pkt_q + 1'b1;
        gcnt_d  = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        gcnt_d = gcnt_q + 1'b1;
        if (gap_done) begin
          if (cont_q && !(stop_pend_q || stop)) begin
            state_d = S_FILL;
            wcnt_d  = '0;
          end else begin
            state_d     = S_IDLE;
            stop_pend_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      cont_q      <= 1'b0;
      nwords_q    <= '0;
      rem_q       <= '0;
      gap_q       <= '0;
      gcnt_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      wcnt_q      <= '0;
      stop_pend_q <= 1'b0;
      wr_en_q     <= 1'b0;
      din_q       <= '0;
      tx_en_q     <= 1'b0;
      dlen_q      <= '0;
      tlen_q      <= '0;
      pkt_q       <= '0;
`ifdef UDP_TX_PATTERN_GEN_PRBS_EN
      prbs_q      <= PRBS_SEED;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cont_q      <= cont_d;
      nwords_q    <= nwords_d;
      rem_q       <= rem_d;
      gap_q       <= gap_d;
      gcnt_q      <= gcnt_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      stop_pend_q <= stop_pend_d;
      wr_en_q     <= wr_en_d;
      din_q       <= din_d;
      tx_en_q     <= tx_en_d;
      dlen_q      <= dlen_d;
      tlen_q      <= tlen_d;
      pkt_q       <= pkt_d;
`ifdef UDP_TX_PATTERN_GEN_PRBS_EN
      prbs_q      <= prbs_d;
`endif
    end
  end

  // NOTE: the pattern RAM is deliberately cleared by reset, so it must stay in flops, not a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PAT_DEPTH; i++) pat_ram[i] <= '0;
    end else if (pat_we) begin
      pat_ram[pat_addr] <= pat_wdata;
    end
  end

  assign wr_en           = wr_en_q;
  assign din             = din_q;
  assign tx_enable       = tx_en_q;
  assign tx_data_length  = dlen_q;
  assign tx_total_length = tlen_q;
  assign busy            = (state_q != S_IDLE);
  assign pkt_count       = pkt_q;

endmodule

// File: tb/tb_udp_tx_pattern_gen.sv
// Self-checking bench for udp_tx_pattern_gen: table vectors, corner sequences, randomized packets.
module tb_udp_tx_pattern_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0, continuous = 1'b0;
  logic [1:0]  mode = '0;
  logic [15:0] payload_bytes = '0, gap_cycles = '0;
  logic        pat_we = 1'b0;
  logic [1:0]  pat_addr = '0;
  logic [63:0] pat_wdata = '0;
  logic        fifo_afull = 1'b0;
  logic        wr_en, tx_enable, busy;
  logic [63:0] din;
  logic [15:0] tx_data_length, tx_total_length, pkt_count;

  udp_tx_pattern_gen dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .continuous(continuous), .payload_bytes(payload_bytes), .gap_cycles(gap_cycles),
    .pat_we(pat_we), .pat_addr(pat_addr), .pat_wdata(pat_wdata), .fifo_afull(fifo_afull),
    .wr_en(wr_en), .din(din), .tx_enable(tx_enable), .tx_data_length(tx_data_length),
    .tx_total_length(tx_total_length), .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0, n_errors = 0;
  int          cyc = 0, start_cyc = 0, stall_viol = 0, overlap = 0;
  logic        afull_seen;
  logic [63:0] wq[$];
  int          wcyc[$], txq[$];
  logic [63:0] pat_model [4];
  logic [15:0] exp_pkts = '0;

  // Observer: records every FIFO write and tx pulse with its edge number.
  always @(posedge clk) begin
    afull_seen = fifo_afull;
    cyc++;
    #1;
    if (wr_en) begin
      wq.push_back(din);
      wcyc.push_back(cyc);
      if (afull_seen) stall_viol++;
    end
    if (tx_enable) txq.push_back(cyc);
    if (wr_en && tx_enable) overlap++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    wq.delete(); wcyc.delete(); txq.delete();
    stall_viol = 0; overlap = 0;
  endtask

`ifdef UDP_TX_PATTERN_GEN_PRBS_EN
  // Bit sequence b[n] = b[n-31] ^ b[n-28] with 31 seed ones of history; word n holds bits 64n..64n+63.
  function automatic logic [63:0] prbs_ref(input int n);
    bit          hist[$];
    bit          nb;
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 31; i++) hist.push_back(1'b1);
    for (int k = 0; k < (n + 1) * 64; k++) begin
      nb = hist[hist.size() - 31] ^ hist[hist.size() - 28];
      hist.push_back(nb);
      if (k >= n * 64) w[k - n * 64] = nb;
    end
    return w;
  endfunction
`endif

  function automatic logic [63:0] model_word(input logic [1:0] m, input int n, input bit last, input int rem);
    logic [63:0] w;
    case (m)
      2'd1:    w = 64'(n % 65536);
`ifdef UDP_TX_PATTERN_GEN_PRBS_EN
      2'd2:    w = prbs_ref(n);
`else
      2'd2:    w = 64'(n % 65536);
`endif
      default: w = pat_model[n % 4];
    endcase
    if (last && rem != 0) w = w & ~((64'd1 << (8 * (8 - rem))) - 64'd1);
    return w;
  endfunction

  task automatic write_pat(input int a, input logic [63:0] d);
    pat_we = 1'b1; pat_addr = 2'(a); pat_wdata = d;
    tick();
    pat_we = 1'b0;
    pat_model[a] = d;
  endtask

  task automatic do_start(input logic [1:0] m, input logic c, input logic [15:0] pb, input logic [15:0] g);
    mode = m; continuous = c; payload_bytes = pb; gap_cycles = g; start = 1'b1;
    tick();
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int rate);
    for (int i = 0; i < 20000; i++) begin
      tick();
      fifo_afull = (rate > 0) && ($urandom_range(99) < rate);
      if (!busy) break;
    end
    fifo_afull = 1'b0;
    check("idle_reached", busy, 0);
  endtask

  task automatic verify_packet(input logic [1:0] m, input int pb);
    int          nw, mism;
    logic [63:0] e;
    nw = (pb + 7) / 8;
    mism = 0;
    check("pkt_word_count", wq.size(), nw);
    for (int i = 0; i < wq.size() && i < nw; i++) begin
      e = model_word(m, i, i == nw - 1, pb % 8);
      if (wq[i] !== e) begin
        if (mism == 0) $display("  first word difference at index %0d: got %h want %h", i, wq[i], e);
        mism++;
      end
    end
    check("pkt_word_mismatches", mism, 0);
    check("pkt_tx_count", txq.size(), 1);
    if (txq.size() > 0 && wcyc.size() > 0)
      check("pkt_tx_after_last_wr", txq[0] - wcyc[wcyc.size() - 1], 1);
    check("pkt_no_overlap", overlap, 0);
    check("pkt_data_length", tx_data_length, 16'(pb + 8));
    check("pkt_total_length", tx_total_length, 16'(pb + 28));
    exp_pkts++;
    check("pkt_count", pkt_count, exp_pkts);
  endtask

  task automatic run_single(input logic [1:0] m, input int pb, input int g, input int rate);
    clear_mon();
    do_start(m, 1'b0, 16'(pb), 16'(g));
    wait_idle(rate);
    verify_packet(m, pb);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_din"}, din, 0);
    check({tag, "_tx_enable"}, tx_enable, 0);
    check({tag, "_data_length"}, tx_data_length, 0);
    check({tag, "_total_length"}, tx_total_length, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pkt_count"}, pkt_count, 0);
  endtask

  typedef struct {
    logic [1:0]  mode;
    int          pb;
    int          exp_nwords;
    logic [15:0] exp_dlen;
    logic [15:0] exp_tlen;
    logic [63:0] exp_last;
  } vec_t;

  initial begin
    vec_t        vecs[7];
    logic [63:0] p0, p1, p2, p3, e;
    int          mism;

    p0 = "HELLO AL";
    p1 = "INX AX51";
    p2 = "INX 6 \n\r";
    p3 = 64'hA5A5_0123_4567_89AB;
    vecs[0] = '{2'd0, 24,    3,    16'd32, 16'd52, p2};
    vecs[1] = '{2'd1, 20,    3,    16'd28, 16'd48, 64'h0};
    vecs[2] = '{2'd0, 13,    2,    16'd21, 16'd41, 64'h494E_5820_4100_0000};
    vecs[3] = '{2'd3, 40,    5,    16'd48, 16'd68, p0};
    vecs[4] = '{2'd1, 8,     1,    16'd16, 16'd36, 64'h0};
    vecs[5] = '{2'd0, 17,    3,    16'd25, 16'd45, 64'h4900_0000_0000_0000};
    vecs[6] = '{2'd0, 65530, 8192, 16'd2,  16'd22, 64'hA5A5_0000_0000_0000};
    for (int i = 0; i < 4; i++) pat_model[i] = '0;

    // Reset state
    tick(); tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    write_pat(0, p0); write_pat(1, p1); write_pat(2, p2); write_pat(3, p3);

    // Table-driven single-shot packets
    for (int v = 0; v < 7; v++) begin
      run_single(vecs[v].mode, vecs[v].pb, 0, 0);
      check("tbl_nwords", wq.size(), vecs[v].exp_nwords);
      if (wq.size() > 0) check("tbl_last_word", wq[wq.size() - 1], vecs[v].exp_last);
      check("tbl_data_length", tx_data_length, vecs[v].exp_dlen);
      check("tbl_total_length", tx_total_length, vecs[v].exp_tlen);
    end

    // afull stall of 5 cycles mid-FILL
    clear_mon();
    do_start(2'd1, 1'b0, 16'd64, 16'd0);
    for (int i = 0; i < 100 && wq.size() < 2; i++) tick();
    fifo_afull = 1'b1;
    repeat (5) tick();
    fifo_afull = 1'b0;
    wait_idle(0);
    verify_packet(2'd1, 64);
    check("stall_no_write_while_afull", stall_viol, 0);
    if (wcyc.size() == 8) check("stall_span", wcyc[7] - wcyc[0], 12);

    // Continuous with stop during second packet
    clear_mon();
    do_start(2'd1, 1'b1, 16'd20, 16'd3);
    check("busy_after_start", busy, 1);
    for (int i = 0; i < 200 && wq.size() < 4; i++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle(0);
    check("cont_tx_count", txq.size(), 2);
    if (txq.size() == 2) check("cont_tx_spacing", txq[1] - txq[0], 7);
    check("cont_word_count", wq.size(), 6);
    if (wcyc.size() > 0) check("first_wr_latency", wcyc[0] - start_cyc, 1);
    mism = 0;
    for (int i = 0; i < wq.size() && i < 6; i++) begin
      e = model_word(2'd1, i, (i % 3) == 2, 4);
      if (wq[i] !== e) mism++;
    end
    check("cont_word_mismatches", mism, 0);
    check("cont_busy_end", busy, 0);
    check("cont_no_overlap", overlap, 0);
    exp_pkts += 2;
    check("cont_pkt_count", pkt_count, exp_pkts);

    // start with zero payload is ignored
    clear_mon();
    do_start(2'd0, 1'b0, 16'd0, 16'd0);
    tick(); tick();
    check("zero_len_busy", busy, 0);
    check("zero_len_words", wq.size(), 0);

    // Mode 2: PRBS when built in, counter otherwise
    run_single(2'd2, 16, 0, 0);

    // Reset during FILL, then a clean packet; the pattern RAM comes back cleared
    clear_mon();
    do_start(2'd1, 1'b0, 16'd80, 16'd0);
    for (int i = 0; i < 100 && wq.size() < 3; i++) tick();
    reset = 1'b1;
    tick();
    check_reset_outputs("midfill_reset");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) pat_model[i] = '0;
    exp_pkts = '0;
    tick();
    run_single(2'd1, 16, 0, 0);
    run_single(2'd0, 8, 0, 0);

    // Randomized packets with random afull back-pressure
    for (int r = 0; r < 20; r++) begin
      for (int a = 0; a < 4; a++) write_pat(a, {$urandom, $urandom});
      run_single(2'($urandom_range(3)), int'($urandom_range(60, 1)), int'($urandom_range(4)), 30);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/udp_tx_pattern_gen.md
# udp_tx_pattern_gen

Parametrised UDP payload source that fills the Ethernet transmit FIFO with packet payload words and then requests transmission. It sits in front of the `udp` transmit path and replaces free-running bench stimulus with a synthesizable generator. It supports configurable data width, pattern depth, payload length, three data modes, single-shot or continuous packets with a programmable inter-packet gap, and length bookkeeping for the UDP/IP headers.

## Interface
- DATA_W, 64, FIFO word width in bits; must be a multiple of 8.
- PAT_DEPTH, 4, number of words in the programmable pattern RAM; minimum 2.
- LEN_W, 16, width of the length and counter fields.
- clk  in  1  generator and FIFO write clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin; ignored unless in IDLE.
- stop  in  1  one-cycle request to end continuous mode after the current packet.
- mode  in  2  data mode: 0 = pattern RAM, 1 = incrementing counter, 2 = PRBS (see Configuration), 3 = reserved (behaves as 0).
- continuous  in  1  sampled at start; 1 repeats packets until stop.
- payload_bytes  in  LEN_W  payload size in bytes; sampled at start.
- gap_cycles  in  LEN_W  idle cycles after each tx_enable pulse; sampled at start.
- pat_we  in  1  pattern RAM write strobe.
- pat_addr  in  $clog2(PAT_DEPTH)  pattern RAM write address.
- pat_wdata  in  DATA_W  pattern RAM write data.
- fifo_afull  in  1  TX FIFO almost-full flag.
- wr_en  out  1  FIFO write strobe.
- din  out  DATA_W  FIFO write data.
- tx_enable  out  1  one-cycle transmit request for the assembled packet.
- tx_data_length  out  LEN_W  UDP length, equal to payload_bytes + 8.
- tx_total_length  out  LEN_W  IP total length, equal to payload_bytes + 28.
- busy  out  1  high in any state other than IDLE.
- pkt_count  out  LEN_W  number of packets completed since reset; wraps to 0.

## Operation
- BYTES = DATA_W/8. Words per packet: nwords = ceil(payload_bytes/BYTES). The unused low-order bytes of the final word are zero.
- FSM states: IDLE, FILL, ARM, GAP.
  - IDLE → FILL: on start with payload_bytes != 0. Samples mode, continuous, payload_bytes and gap_cycles, and clears the word counter and the pattern index.
  - A start with payload_bytes == 0 is ignored.
  - FILL: in each cycle where fifo_afull == 0, issue one word (wr_en = 1 on the next edge) and advance the word counter. After word nwords-1 is issued, go to ARM.
  - ARM: tx_enable = 1 for exactly one cycle. pkt_count increments. Go to GAP.
  - GAP: count gap_cycles cycles (gap_cycles == 0 means leave after 1 cycle). Then go to FILL if continuous is set and no stop is pending; otherwise go to IDLE.
- stop is latched as pending in any non-IDLE state and cleared on entry to IDLE. It never truncates a packet that is being filled.
- Data modes:
  - Mode 0: word = pat_ram[idx]; idx wraps to 0 after PAT_DEPTH-1 and continues across packet boundaries.
  - Mode 1: word = running LEN_W counter zero-extended to DATA_W; the counter resets at each start.
  - Mode 2: word = PRBS output (see Configuration).
- The pattern RAM is writable in any state. A write to the index being read in the same cycle returns the old data. All RAM entries reset to 0.
- tx_data_length and tx_total_length are registered at start and held until the next start. Additions truncate to LEN_W.
- Simultaneous start and stop in IDLE: start is accepted and stop is ignored.

## Timing
- Reset values: wr_en = 0, din = 0, tx_enable = 0, tx_data_length = 0, tx_total_length = 0, busy = 0, pkt_count = 0. FSM = IDLE, stop pending cleared.
- Reset asserted mid-packet: all of the above apply on the next edge. Words already written to the FIFO are not retracted.
- start sampled at edge N: busy = 1 from edge N+1. The earliest wr_en is at edge N+2.
- fifo_afull is sampled in the cycle before the write. With fifo_afull held low, FILL issues one word per cycle, back to back.
- tx_enable rises on the edge after the last wr_en and is never asserted in the same cycle as wr_en.
- Minimum packet period in continuous mode with afull low: nwords + 1 + max(gap_cycles, 1) cycles.

## Configuration
- UDP_TX_PATTERN_GEN_PRBS_EN defined: mode 2 uses a PRBS-31 LFSR (x^31 + x^28 + 1) seeded with 31'h7FFFFFFF at start, advanced DATA_W steps per word, LSB first.
- Undefined: no LFSR is built and mode 2 behaves as mode 1.

## Test plan
- DATA_W = 64, pattern RAM loaded with three words ("HELLO AL", "INX AX51", "INX 6 \n\r") plus a fourth word, mode 0, payload_bytes = 24, fifo_afull = 0 → three consecutive wr_en with those words; tx_enable one cycle later; tx_data_length = 32, tx_total_length = 52; pkt_count = 1.
- payload_bytes = 20, mode 1 → three words 0, 1, 2, with the last word's low 4 bytes zero; tx_enable once.
- fifo_afull toggled high for 5 cycles mid-FILL → wr_en = 0 during the stall; no word lost or duplicated; the word order is preserved.
- continuous = 1, gap_cycles = 3, stop pulsed during the second packet's FILL → exactly two complete packets; tx_enable pulses are 3 + nwords + 1 cycles apart; ends in IDLE with busy = 0.
- reset pulsed during FILL → all outputs return to their reset values on the next edge; a subsequent start produces a clean packet.
- With the macro defined, mode 2 → the first word matches the reference PRBS-31 model; without the macro, mode 2 output equals mode 1.
